axi_memory_slave_burst: RTL

// - AXI4 responder (slave) with burst support; the memory end of the AXI burst master.
// - Owns a word-addressed on-chip RAM of 2**MEM_ADDR_WIDTH words.
// - Serves independent write (AW/W/B) and read (AR/R) channels, one outstanding transaction each.
// - Sits behind the frame/stream master as the frame buffer.

---
 rtl/axi_memory_slave_burst_pkg.sv | 33 +++
 rtl/axi_memory_slave_burst_addr_gen.sv | 30 +++
 rtl/axi_memory_slave_burst.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_memory_slave_burst_pkg.sv
// Shared AXI types for the burst memory responder: burst encodings, response codes,
// channel state enums and the WRAP-length legality helper.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

  // WRAP bursts are only defined for 2, 4, 8 or 16 beats (len = beats-1).
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_memory_slave_burst_addr_gen.sv
// Combinational per-beat word-address stepper for FIXED/INCR/WRAP bursts.
// Illegal WRAP lengths and the reserved encoding step as INCR.
module axi_burst_addr_gen
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]            i_len,
  input  logic [1:0]            i_burst,
  output logic [ADDR_WIDTH-1:0] o_next_addr,
  output logic                  o_wrap_legal
);

  logic [ADDR_WIDTH-1:0] w_incr;
  logic [ADDR_WIDTH-1:0] w_mask;

  always_comb begin
    w_incr       = i_addr + ADDR_WIDTH'(1);
    w_mask       = ADDR_WIDTH'(i_len);
    o_wrap_legal = wrap_len_ok(i_len);
    case (burst_t'(i_burst))
      BURST_FIXED: o_next_addr = i_addr;
      // len+1 is a power of two here, so len itself is the in-block offset mask
      BURST_WRAP:  o_next_addr = o_wrap_legal ? ((i_addr & ~w_mask) | (w_incr & w_mask)) : w_incr;
      default:     o_next_addr = w_incr;
    endcase
  end

endmodule

// File: rtl/axi_memory_slave_burst.sv
// AXI4 burst memory responder: word-addressed on-chip RAM with independent
// write (AW/W/B) and read (AR/R) channels, one outstanding transaction each.
module axi_memory_slave_burst
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int MEM_DEPTH = 1 << MEM_ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  // Transfer size is accepted but has no effect on a word-addressed memory.
  logic w_unused_size;
  assign w_unused_size = ^{awsize, arsize};

  // ---------------- write channel ----------------
  wstate_t               r_wstate;
  logic [ID_WIDTH-1:0]   r_wid;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [7:0]            r_wlen;
  burst_t                r_wburst;
  logic [8:0]            r_wcnt;
  logic                  r_werr;
  logic                  r_bvalid;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp;

  logic [ADDR_WIDTH-1:0] w_wnext;
  logic                  w_wwrap_ok;
  logic                  w_woor;
  logic                  w_wover;
  logic                  w_wbeat;
  logic                  w_wbeat_err;
  logic                  w_mem_we;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_wgen (
    .i_addr       (r_waddr),
    .i_len        (r_wlen),
    .i_burst      (r_wburst),
    .o_next_addr  (w_wnext),
    .o_wrap_legal (w_wwrap_ok)
  );

  assign w_woor      = |r_waddr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign w_wover     = r_wcnt > {1'b0, r_wlen};
  assign w_wbeat     = (r_wstate == W_DATA) && wvalid;
  assign w_wbeat_err = w_woor || w_wover || ((r_wburst == BURST_WRAP) && !w_wwrap_ok);
  assign w_mem_we    = w_wbeat && !w_woor && !w_wover;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wstate <= W_IDLE;
      r_wid    <= '0;
      r_waddr  <= '0;
      r_wlen   <= '0;
      r_wburst <= BURST_FIXED;
      r_wcnt   <= '0;
      r_werr   <= 1'b0;
      r_bvalid <= 1'b0;
      r_bid    <= '0;
      r_bresp  <= RESP_OKAY;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (awvalid) begin
            r_wid    <= awid;
            r_waddr  <= awaddr;
            r_wlen   <= awlen;
            r_wburst <= burst_t'(awburst);
            r_wcnt   <= '0;
            r_werr   <= 1'b0;
            r_wstate <= W_DATA;
          end
        end
        W_DATA: begin
          if (wvalid) begin
            r_waddr <= w_wnext;
            // saturate so overlong bursts keep flagging beats past awlen
            if (r_wcnt != '1) r_wcnt <= r_wcnt + 9'd1;
            r_werr <= r_werr || w_wbeat_err;
            if (wlast) begin
              r_wstate <= W_RESP;
              r_bvalid <= 1'b1;
              r_bid    <= r_wid;
              r_bresp  <= (r_werr || w_wbeat_err) ? RESP_SLVERR : RESP_OKAY;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid <= 1'b0;
            r_wstate <= W_IDLE;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) r_mem[r_waddr[MEM_ADDR_WIDTH-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

  assign awready = (r_wstate == W_IDLE);
  assign wready  = (r_wstate == W_DATA);
  assign bvalid  = r_bvalid;
  assign bid     = r_bid;
  assign bresp   = r_bresp;

  // ---------------- read channel ----------------
  rstate_t               r_rstate;
  logic [ID_WIDTH-1:0]   r_rid;
  logic [ADDR_WIDTH-1:0] r_raddr;
  logic [7:0]            r_rlen;
  burst_t                r_rburst;
  logic [7:0]            r_rcnt;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic [ADDR_WIDTH-1:0] w_rnext;
  logic                  w_rwrap_ok;
  logic [ADDR_WIDTH-1:0] w_rfetch_addr;
  logic                  w_rfetch_oor;
  logic [DATA_WIDTH-1:0] w_rfetch_data;
  logic                  w_ar_wrap_bad;
  logic                  w_r_wrap_bad;

  axi_burst_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH)) u_rgen (
    .i_addr       (r_raddr),
    .i_len        (r_rlen),
    .i_burst      (r_rburst),
    .o_next_addr  (w_rnext),
    .o_wrap_legal (w_rwrap_ok)
  );

  // Fetch the next beat at the handshake edge so a new beat appears every cycle.
  assign w_rfetch_addr = (r_rstate == R_IDLE) ? araddr : w_rnext;
  assign w_rfetch_oor  = |w_rfetch_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH];
  assign w_rfetch_data = w_rfetch_oor ? '0 : r_mem[w_rfetch_addr[MEM_ADDR_WIDTH-1:0]];
  assign w_ar_wrap_bad = (burst_t'(arburst) == BURST_WRAP) && !wrap_len_ok(arlen);
  assign w_r_wrap_bad  = (r_rburst == BURST_WRAP) && !w_rwrap_ok;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rburst <= BURST_FIXED;
      r_rcnt   <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (arvalid) begin
            r_rid    <= arid;
            r_raddr  <= araddr;
            r_rlen   <= arlen;
            r_rburst <= burst_t'(arburst);
            r_rcnt   <= '0;
            r_rvalid <= 1'b1;
            r_rdata  <= w_rfetch_data;
            r_rresp  <= (w_rfetch_oor || w_ar_wrap_bad) ? RESP_SLVERR : RESP_OKAY;
            r_rlast  <= (arlen == 8'd0);
            r_rstate <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (r_rlast) begin
              r_rvalid <= 1'b0;
              r_rlast  <= 1'b0;
              r_rstate <= R_IDLE;
            end else begin
              r_raddr <= w_rnext;
              r_rcnt  <= r_rcnt + 8'd1;
              r_rdata <= w_rfetch_data;
              r_rresp <= (w_rfetch_oor || w_r_wrap_bad) ? RESP_SLVERR : RESP_OKAY;
              r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
            end
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign arready = (r_rstate == R_IDLE);
  assign rvalid  = r_rvalid;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;

endmodule
